// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one div32x32 divider between NUM_REQ requesters.
// Optional watchdog enabled by defining DIV_TIMEOUT_EN.
module div_share_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*32-1:0] req_dividend,
  input  logic [NUM_REQ*32-1:0] req_divisor,
  input  logic [NUM_REQ-1:0]    req_signed,
  input  logic [NUM_REQ-1:0]    req_trunc16,
  output logic [NUM_REQ-1:0]    done,
  output logic [31:0]           result,
  output logic                  busy,
  output logic [IDX_W-1:0]      gnt_idx,
  output logic                  div_start,
  output logic [31:0]           div_dividend,
  output logic [31:0]           div_divisor,
  output logic                  div_signed,
  output logic                  div_trunc16,
  input  logic [31:0]           div_out,
  input  logic [1:0]            div_state,
  output logic                  div_err
);

  // Handshake: a requester raises req with stable operands and keeps it high
  // until its done bit pulses; operands are captured at grant, so the request
  // is "accepted" at grant and "completed" at the done pulse. A req still high
  // when the FSM is back in IDLE is a new request.

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  localparam logic [1:0] DIV_IDLE     = 2'd0;
  localparam logic [1:0] DIV_COMPLETE = 2'd2;

  logic [1:0]         state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   sel;
  logic               any_req;
  logic [IDX_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] gnt_onehot;

  // Search upward from the pointer, wrapping at NUM_REQ.
  always_comb begin
    logic [IDX_W:0] cand;
    logic           found;
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        sel   = cand[IDX_W-1:0];
      end
    end
  end

  assign any_req    = |req;
  assign next_ptr   = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
  assign gnt_onehot = NUM_REQ'(1) << gnt_idx;
  assign busy       = (state != S_IDLE);

`ifdef DIV_TIMEOUT_EN
  logic [7:0] tcnt;
  logic       expired;
  assign expired = (tcnt == 8'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = 32'(TIMEOUT_CYCLES);
  assign div_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ptr          <= '0;
      gnt_idx      <= '0;
      done         <= '0;
      result       <= '0;
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      div_signed   <= 1'b0;
      div_trunc16  <= 1'b0;
`ifdef DIV_TIMEOUT_EN
      tcnt         <= '0;
      div_err      <= 1'b0;
`endif
    end else begin
      done <= '0;
      case (state)
        S_IDLE: begin
          // A divider still finishing an op from before reset blocks grants.
          if (any_req && div_state == DIV_IDLE) begin
            gnt_idx      <= sel;
            div_dividend <= req_dividend[32*sel +: 32];
            div_divisor  <= req_divisor[32*sel +: 32];
            div_signed   <= req_signed[sel];
            div_trunc16  <= req_trunc16[sel];
            div_start    <= 1'b1;
            state        <= S_RUN;
`ifdef DIV_TIMEOUT_EN
            tcnt         <= '0;
`endif
          end
        end
        S_RUN: begin
          if (div_state == DIV_COMPLETE) begin
            result    <= div_out;
            done      <= gnt_onehot;
            div_start <= 1'b0;
            ptr       <= next_ptr;
            state     <= S_RELEASE;
`ifdef DIV_TIMEOUT_EN
            tcnt      <= tcnt + 8'd1;
          end else if (expired) begin
            result    <= 32'hFFFF_FFFF;
            done      <= gnt_onehot;
            div_start <= 1'b0;
            div_err   <= 1'b1;
            ptr       <= next_ptr;
            state     <= S_RELEASE;
            tcnt      <= '0;
          end else begin
            tcnt      <= tcnt + 8'd1;
`endif
          end
        end
        S_RELEASE: begin
          if (div_state == DIV_IDLE) begin
            state <= S_IDLE;
`ifdef DIV_TIMEOUT_EN
          end else if (expired) begin
            state <= S_IDLE;
            tcnt  <= '0;
          end else begin
            tcnt  <= tcnt + 8'd1;
`endif
          end
        end
        default: begin
          state     <= S_IDLE;
          div_start <= 1'b0;
        end
      endcase
    end
  end

endmodule
